// File: rtl/ospi_flash_pkg.sv
// Shared types and helpers for the behavioural OSPI NOR flash array.
// Holds the controller state encoding, the erased-word pattern and sector address math.
package ospi_flash_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        PROGRAM,
        ERASE
    } state_t;

    // Sliced down to DATA_WIDTH by users; caps supported word width at 64 bits.
    localparam logic [63:0] ERASED_WORD = '1;

    function automatic logic [31:0] sector_base(input logic [31:0] addr, input int unsigned sector_words);
        return addr & ~(sector_words - 32'd1);
    endfunction

endpackage

// File: rtl/ospi_flash_array.sv
// Single-port DEPTH x DATA_WIDTH synchronous RAM, one write port, no byte mask.
// Read data is registered (one cycle) and read-before-write on the same address.
module ospi_flash_array
    import ospi_flash_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ospi_flash_mem.sv
// NOR-style flash array behind the OSPI strobes: self-erase after reset, timed program (AND) and sector/chip erase.
// Reads return data the next cycle; strobes are rejected with an error pulse while busy or when more than one is raised.
module ospi_flash_mem
    import ospi_flash_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int SECTOR_WORDS = 16,
    parameter int PROG_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic                  read_enable,
    input  logic                  erase_enable,
    input  logic                  chip_erase,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  error
);

    localparam int PCW = $clog2(PROG_CYCLES + 1);
    localparam logic [DATA_WIDTH-1:0] ERASED = ERASED_WORD[DATA_WIDTH-1:0];

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] wcnt, wcnt_n;
    logic [ADDR_WIDTH-1:0] base, base_n;
    logic [ADDR_WIDTH-1:0] last, last_n;
    logic [PCW-1:0]        pcnt, pcnt_n;
    logic [ADDR_WIDTH-1:0] paddr, paddr_n;
    logic [DATA_WIDTH-1:0] pdata, pdata_n;
    logic [DATA_WIDTH-1:0] data_hold;
    logic                  dv_n, err_n;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata;

    logic [3:0] strobes;
    logic       any_strobe, multi_strobe;

    assign strobes      = {write_enable, read_enable, erase_enable, chip_erase};
    assign any_strobe   = |strobes;
    assign multi_strobe = ($countones(strobes) > 1);

    ospi_flash_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(mem_wdata),
        .rdata(mem_rdata)
    );

    always_comb begin
        state_n   = state;
        wcnt_n    = wcnt;
        base_n    = base;
        last_n    = last;
        pcnt_n    = pcnt;
        paddr_n   = paddr;
        pdata_n   = pdata;
        dv_n      = 1'b0;
        err_n     = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = address;
        mem_wdata = pdata;

        case (state)
            // Reset self-erase and user erases share the same pointer walk.
            INIT, ERASE: begin
                mem_we    = 1'b1;
                mem_addr  = base + wcnt;
                mem_wdata = ERASED;
                err_n     = any_strobe;
                if (wcnt == last) begin
                    state_n = IDLE;
                    wcnt_n  = '0;
                end else begin
                    wcnt_n = wcnt + 1'b1;
                end
            end
            // The array keeps reading paddr, so rdata holds the current word on the commit cycle.
            PROGRAM: begin
                mem_addr = paddr;
                err_n    = any_strobe;
                if (pcnt == PCW'(PROG_CYCLES - 1)) begin
                    mem_we    = 1'b1;
                    mem_wdata = mem_rdata & pdata;
                    state_n   = IDLE;
                end else begin
                    pcnt_n = pcnt + 1'b1;
                end
            end
            IDLE: begin
                if (multi_strobe) begin
                    err_n = 1'b1;
                end else if (read_enable) begin
                    dv_n = 1'b1;
                end else if (write_enable) begin
                    paddr_n = address;
                    pdata_n = data_in;
                    pcnt_n  = '0;
                    state_n = PROGRAM;
                end else if (erase_enable) begin
                    base_n  = ADDR_WIDTH'(sector_base(32'(address), SECTOR_WORDS));
                    last_n  = ADDR_WIDTH'(SECTOR_WORDS - 1);
                    wcnt_n  = '0;
                    state_n = ERASE;
                end else if (chip_erase) begin
                    base_n  = '0;
                    last_n  = '1;
                    wcnt_n  = '0;
                    state_n = ERASE;
                end
            end
            default: state_n = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT;
            wcnt       <= '0;
            base       <= '0;
            last       <= '1;
            pcnt       <= '0;
            paddr      <= '0;
            pdata      <= '0;
            data_valid <= 1'b0;
            error      <= 1'b0;
            data_hold  <= '0;
        end else begin
            state      <= state_n;
            wcnt       <= wcnt_n;
            base       <= base_n;
            last       <= last_n;
            pcnt       <= pcnt_n;
            paddr      <= paddr_n;
            pdata      <= pdata_n;
            data_valid <= dv_n;
            error      <= err_n;
            if (data_valid) begin
                data_hold <= mem_rdata;
            end
        end
    end

    // rdata changes on every cycle, so the last read result is held separately.
    assign data_out = data_valid ? mem_rdata : data_hold;
    assign busy     = (state != IDLE);

endmodule
